dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the MIPS CPU core, sitting between the CPU load/store port and on-chip data RAM. It generalises the fixed single-cycle data RAM: programmable base address and depth, configurable wait states with a req/ack stall handshake, byte/half/word access with sign extension, and fault reporting. The CPU holds its pipeline while busy is high.

Parameters:
BASE_ADDR, 32'h10010000, byte address mapped to RAM word 0
DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two, 16..65536
WAIT_CYCLES, 1, extra wait states per access, 0..15

Ports:
clk_in  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request, sampled in IDLE only
we  input  1  1 = store, 0 = load; sampled with req
sel  input  3  access size/sign; sampled with req
addr  input  32  byte address (CPU virtual); sampled with req
wdata  input  32  store data, right-aligned; sampled with req
rdata  output  32  load result, extended to 32 bits; valid when ack
ack  output  1  one-cycle completion pulse
fault  output  1  qualifies ack: access rejected
busy  output  1  high from the cycle after req acceptance until ack inclusive

Behaviour:
- Reset: async assert to state IDLE; rdata=0, ack=0, fault=0, busy=0, wait counter=0. RAM contents are not cleared.
- Reset mid-access aborts it. A store not yet committed is dropped. No ack is issued.
- sel encoding:
  - 000 word
  - 001 half, zero-extend
  - 010 half, sign-extend
  - 011 byte, zero-extend
  - 100 byte, sign-extend
  - 101..111 illegal
- Offset = addr - BASE_ADDR, 32-bit modular. Word index = offset[31:2]. Byte lanes are little-endian: byte k at bits 8k+7:8k.
- Fault conditions, checked at acceptance:
  - offset >= 4*DEPTH_WORDS (includes addr < BASE_ADDR via wrap)
  - half access with offset[0]=1
  - word access with offset[1:0] != 0
  - illegal sel
- A faulted access never touches RAM. It still runs the full wait sequence; ack=1, fault=1, rdata=0.
- FSM states are IDLE, WAIT, DONE.
- IDLE:
  - On req=1, latch we/sel/offset/wdata/fault flag.
  - If WAIT_CYCLES=0, go to DONE; else go to WAIT with counter=WAIT_CYCLES-1.
  - req=0 stays in IDLE.
- WAIT: decrement the counter; at 0, go to DONE.
- Commit point is the clock edge entering DONE:
  - Store: write only the selected byte lanes (byte-enable). Unselected bytes are unchanged.
  - Load: RAM read, lane extraction and extension are registered into rdata.
- DONE: ack=1 for exactly one cycle, fault valid, busy=1. Next state is IDLE unconditionally.
- Latency: ack is asserted WAIT_CYCLES+1 cycles after the req-sampling edge. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- req while busy is ignored: not queued, no effect.
- req in the same cycle as ack is also ignored; the requester must re-assert it in IDLE.
- rdata holds its last value until the next load's ack. After a store ack it is 0. After a fault it is 0.
- Load followed by a store to the same address returns the pre-store data, since accesses are strictly serialised.
- Width rules:
  - Internal word index is clog2(DEPTH_WORDS) bits.
  - Store half uses wdata[15:0]; store byte uses wdata[7:0]; both are replicated to the addressed lane.

Decomposition:
- Shared package mem_pkg holds:
  - the sel encoding constants (SEL_W, SEL_HU, SEL_HS, SEL_BU, SEL_BS)
  - the FSM state enum
  - a function computing the 4-bit byte-enable from sel and offset[1:0]
- One natural sub-module: dmem_ram. It is a single-port synchronous RAM, DEPTH_WORDS x 32, with a 4-bit byte-write enable and registered read, instanced by dmem_ctrl.
- The extraction/extension mux stays in dmem_ctrl.

Test Plan:
- Reset values: WAIT_CYCLES=1; assert reset mid-WAIT of a store to 32'h10010000 data 32'hDEADBEEF -> busy/ack drop immediately. A later word load of 32'h10010000 returns the prior value (0 after preload), not DEADBEEF.
- Word round-trip: store 32'h12345678 at 32'h10010010 -> ack exactly 2 cycles after req edge, fault=0. Load word from the same address -> rdata=32'h12345678.
- Lanes and extension: after the above, load byte-signed at 32'h10010013 -> 32'h00000012. Store byte 8'hF0 at 32'h10010011, then load byte-signed at 32'h10010011 -> 32'hFFFFFFF0. Load half-unsigned at 32'h10010010 -> 32'h0000F078.
- Faults:
  - word load at 32'h10010002 -> ack with fault=1, rdata=0
  - load at 32'h1000FFFC -> fault
  - load at BASE+4*DEPTH_WORDS -> fault
  - sel=3'b111 -> fault
  - memory unchanged in all cases
- Handshake: hold req=1 continuously with WAIT_CYCLES=0 -> ack every 2nd cycle. A req toggled during busy is ignored, giving exactly one ack per accepted request.
- Parameter sweep: WAIT_CYCLES=0, 3, 15 and DEPTH_WORDS=16 -> latency equals WAIT_CYCLES+1. Access to BASE+60 succeeds and BASE+64 faults.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encodings, controller FSM states and byte-enable helper
package mem_pkg;
  localparam logic [2:0] SEL_W  = 3'd0;
  localparam logic [2:0] SEL_HU = 3'd1;
  localparam logic [2:0] SEL_HS = 3'd2;
  localparam logic [2:0] SEL_BU = 3'd3;
  localparam logic [2:0] SEL_BS = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  function automatic logic [3:0] byte_en(input logic [2:0] s, input logic [1:0] lo);
    return s == SEL_W ? 4'b1111 :
           (s == SEL_HU || s == SEL_HS) ? (lo[1] ? 4'b1100 : 4'b0011) :
           4'b0001 << lo;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port DEPTH x 32 RAM, byte-write enables, registered read (ports: clk, en, be, addr, wdata, rdata)
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: CPU data-memory controller with wait states, byte/half/word access and faults (ports: clk_in, reset, req/we/sel/addr/wdata in, rdata/ack/fault/busy out)
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        fault,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t        state;
  logic [3:0]    cnt;
  logic          l_we, l_flt;
  logic [2:0]    l_sel;
  logic [AW-1:0] l_idx;
  logic [1:0]    l_lo;
  logic [31:0]   l_wdata, rdata_q;
  logic          idle, go_done, in_flt, c_we, c_flt;
  logic [2:0]    c_sel;
  logic [AW-1:0] c_idx;
  logic [1:0]    c_lo;
  logic [31:0]   off, c_wdata, c_wr, q, ext;
  logic [15:0]   sh;
  assign off    = addr - BASE_ADDR;
  assign idle   = state == ST_IDLE;
  assign in_flt = off[31:AW+2] != '0 || sel > SEL_BS ||
                  (sel == SEL_W && off[1:0] != 2'b00) ||
                  ((sel == SEL_HU || sel == SEL_HS) && off[0]);
  // With zero wait states the commit edge is the acceptance edge, so the RAM
  // must see the live request in IDLE and the latched one afterwards.
  assign c_we    = idle ? we : l_we;
  assign c_flt   = idle ? in_flt : l_flt;
  assign c_sel   = idle ? sel : l_sel;
  assign c_idx   = idle ? off[AW+1:2] : l_idx;
  assign c_lo    = idle ? off[1:0] : l_lo;
  assign c_wdata = idle ? wdata : l_wdata;
  assign go_done = idle ? req && WAIT_CYCLES == 0 : state == ST_WAIT && cnt == 4'd0;
  assign c_wr    = c_sel == SEL_W ? c_wdata :
                   (c_sel == SEL_HU || c_sel == SEL_HS) ? {2{c_wdata[15:0]}} : {4{c_wdata[7:0]}};
  dmem_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk   (clk_in),
    .en    (go_done && !c_flt),
    .be    (c_we ? byte_en(c_sel, c_lo) : 4'b0000),
    .addr  (c_idx),
    .wdata (c_wr),
    .rdata (q)
  );
  assign sh  = 16'(q >> {l_lo, 3'b000});
  assign ext = (l_flt || l_we) ? 32'd0 :
               l_sel == SEL_W  ? q :
               l_sel == SEL_HU ? {16'd0, sh} :
               l_sel == SEL_HS ? {{16{sh[15]}}, sh} :
               l_sel == SEL_BU ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
  assign ack   = state == ST_DONE;
  assign fault = ack && l_flt;
  assign busy  = !idle;
  // The RAM output register holds the committed word during DONE; rdata_q keeps it afterwards.
  assign rdata = ack ? ext : rdata_q;
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      l_we    <= 1'b0;
      l_flt   <= 1'b0;
      l_sel   <= SEL_W;
      l_idx   <= '0;
      l_lo    <= 2'b00;
      l_wdata <= 32'd0;
      rdata_q <= 32'd0;
    end else if (idle) begin
      if (req) begin
        state   <= WAIT_CYCLES == 0 ? ST_DONE : ST_WAIT;
        cnt     <= CNT_INIT;
        l_we    <= we;
        l_flt   <= in_flt;
        l_sel   <= sel;
        l_idx   <= off[AW+1:2];
        l_lo    <= off[1:0];
        l_wdata <= wdata;
      end
    end else if (state == ST_WAIT) begin
      state <= cnt == 4'd0 ? ST_DONE : ST_WAIT;
      cnt   <= cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else begin
      state   <= ST_IDLE;
      rdata_q <= ext;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl across wait/depth configurations
module tb_dmem_ctrl;
  localparam logic [31:0] BASE = 32'h10010000;
  logic clk;
  int n_chk = 0;
  int n_err = 0;
  logic [3:0] done = 4'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 15;
    localparam int D = g == 0 ? 1024 : 16;
    logic rst, req, we, ack, fault, busy;
    logic [2:0] sel;
    logic [31:0] addr, wdata, rdata;
    logic [7:0] mb [4*D];

    dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
      .clk_in(clk), .reset(rst), .req(req), .we(we), .sel(sel), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ack(ack), .fault(fault), .busy(busy));

    task automatic model(input logic w, input logic [2:0] s, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] r, output logic f);
      int n;
      logic [31:0] off, v;
      off = a - BASE;
      n = s == 3'd0 ? 4 : s <= 3'd2 ? 2 : 1;
      f = s > 3'd4 || off >= 32'(4*D) || off % n != 0;
      r = 0;
      v = 0;
      if (!f) begin
        if (w) for (int i = 0; i < n; i++) mb[off+i] = d[8*i +: 8];
        else begin
          for (int i = 0; i < n; i++) v[8*i +: 8] = mb[off+i];
          if (s == 3'd2 && v[15]) v[31:16] = '1;
          if (s == 3'd4 && v[7]) v[31:8] = '1;
          r = v;
        end
      end
    endtask

    task automatic acc(input logic w, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] d, input bit noise, output logic [31:0] r, output logic f);
      int k;
      logic [31:0] er;
      logic ef;
      model(w, s, a, d, er, ef);
      @(posedge clk); #1;
      we = w; sel = s; addr = a; wdata = d; req = 1;
      @(posedge clk); #1;
      k = 1;
      while (!ack && k < 64) begin
        if (noise) begin
          req = 1'($urandom_range(0, 1)); we = 1'($urandom); sel = 3'($urandom);
          addr = $urandom; wdata = $urandom;
        end else req = 0;
        @(posedge clk); #1;
        k++;
      end
      req = noise;
      r = rdata;
      f = fault;
      chk($sformatf("g%0d latency", g), 32'(k), 32'(W + 1));
      chk($sformatf("g%0d fault @%h sel%0d", g, a, s), {31'd0, f}, {31'd0, ef});
      chk($sformatf("g%0d rdata @%h sel%0d", g, a, s), r, er);
      @(posedge clk); #1;
      chk($sformatf("g%0d idle after ack", g), {30'd0, ack, busy}, 32'd0);
      chk($sformatf("g%0d rdata hold", g), rdata, er);
      req = 0;
    endtask

    initial begin
      logic [31:0] r, er, a, d;
      logic f, ef, w;
      logic [2:0] s;
      int na, n, pick;
      rst = 1; req = 0; we = 0; sel = 0; addr = 0; wdata = 0;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("g%0d reset rdata", g), rdata, 32'd0);
      chk($sformatf("g%0d reset flags", g), {29'd0, ack, fault, busy}, 32'd0);
      rst = 0;
      for (int i = 0; i < D; i++) acc(1, 3'd0, BASE + 32'(4*i), i == 0 ? 32'd0 : $urandom, 0, r, f);
      // reset during an access in flight
      @(posedge clk); #1;
      we = 1; sel = 3'd0; addr = BASE; wdata = 32'hDEADBEEF; req = 1;
      @(posedge clk); #1;
      req = 0;
      chk($sformatf("g%0d busy before abort", g), {31'd0, busy}, 32'd1);
      if (W == 0) model(1, 3'd0, BASE, 32'hDEADBEEF, er, ef);
      #2 rst = 1;
      #1;
      chk($sformatf("g%0d abort flags", g), {29'd0, ack, fault, busy}, 32'd0);
      chk($sformatf("g%0d abort rdata", g), rdata, 32'd0);
      @(posedge clk); #1;
      rst = 0;
      acc(0, 3'd0, BASE, 0, 0, r, f);
      chk($sformatf("g%0d abort dropped", g), r, W > 0 ? 32'd0 : 32'hDEADBEEF);
      // directed lane / extension
      acc(1, 3'd0, BASE + 32'h10, 32'h12345678, 0, r, f);
      acc(0, 3'd0, BASE + 32'h10, 0, 0, r, f);
      chk($sformatf("g%0d word rt", g), r, 32'h12345678);
      acc(0, 3'd4, BASE + 32'h13, 0, 0, r, f);
      chk($sformatf("g%0d byte3 bs", g), r, 32'h00000012);
      acc(1, 3'd3, BASE + 32'h11, 32'h000000F0, 0, r, f);
      acc(0, 3'd4, BASE + 32'h11, 0, 0, r, f);
      chk($sformatf("g%0d byte1 bs", g), r, 32'hFFFFFFF0);
      acc(0, 3'd1, BASE + 32'h10, 0, 0, r, f);
      chk($sformatf("g%0d half hu", g), r, 32'h0000F078);
      // faults
      acc(0, 3'd0, BASE + 32'h2, 0, 0, r, f);
      chk($sformatf("g%0d misalign fault", g), {31'd0, f}, 32'd1);
      acc(0, 3'd0, BASE - 32'h4, 0, 0, r, f);
      chk($sformatf("g%0d below fault", g), {31'd0, f}, 32'd1);
      acc(0, 3'd0, BASE + 32'(4*D), 0, 0, r, f);
      chk($sformatf("g%0d above fault", g), {31'd0, f}, 32'd1);
      acc(0, 3'd7, BASE + 32'h10, 0, 0, r, f);
      chk($sformatf("g%0d sel7 fault", g), {31'd0, f}, 32'd1);
      acc(1, 3'd0, BASE + 32'h12, 32'hCAFEF00D, 0, r, f);
      acc(1, 3'd6, BASE + 32'h10, 32'hCAFEF00D, 0, r, f);
      acc(0, 3'd0, BASE + 32'h10, 0, 0, r, f);
      chk($sformatf("g%0d mem unchanged", g), r, 32'h1234F078);
      acc(0, 3'd0, BASE + 32'(4*D - 4), 0, 0, r, f);
      chk($sformatf("g%0d last word ok", g), {31'd0, f}, 32'd0);
      // continuous request
      model(0, 3'd0, BASE + 32'h8, 0, er, ef);
      @(posedge clk); #1;
      we = 0; sel = 3'd0; addr = BASE + 32'h8; req = 1; na = 0;
      for (int c = 1; c <= 4*(W+2); c++) begin
        @(posedge clk); #1;
        chk($sformatf("g%0d stream ack c%0d", g, c), {31'd0, ack}, {31'd0, c % (W+2) == W+1});
        if (ack) begin
          na++;
          chk($sformatf("g%0d stream rdata", g), rdata, er);
        end
      end
      req = 0;
      chk($sformatf("g%0d stream count", g), 32'(na), 32'd4);
      @(posedge clk); #1;
      chk($sformatf("g%0d stream idle", g), {31'd0, busy}, 32'd0);
      // random traffic
      for (int i = 0; i < 150; i++) begin
        w = 1'($urandom_range(0, 1));
        pick = $urandom_range(0, 9);
        s = pick > 7 ? 3'd0 : 3'(pick);
        n = $urandom_range(0, 15);
        a = n == 0 ? $urandom : n == 1 ? BASE + 32'(4*D) + 32'($urandom_range(0, 7)) :
            BASE + 32'($urandom_range(0, 4*D-1));
        if ($urandom_range(0, 3) != 0)
          a[1:0] = s == 3'd0 ? 2'b00 : s <= 3'd2 ? {a[1], 1'b0} : a[1:0];
        d = $urandom;
        acc(w, s, a, d, 1'($urandom_range(0, 1)), r, f);
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 95000 && !(&done); c++) @(posedge clk);
    chk("all configs done", {28'd0, done}, 32'hF);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
